step_decoder: RTL and testbench



---
 rtl/step_decoder_if.sv | 41 ++++
 rtl/step_decoder.sv | 168 ++++++++++++++++
 tb/tb_step_decoder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/step_decoder_if.sv
// Stepper/IR/flags inputs plus the registered datapath controls of the step decoder.
// The decoder side is the slave modport; the stepper/datapath side is the master.
interface step_decoder_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       step;
    logic [7:0]       ir;
    logic [3:0]       flags;
    logic             halt_req;
    logic             halted;
    logic [3:0]       reg_en;
    logic [3:0]       reg_set;
    logic             en_iar;
    logic             set_iar;
    logic             set_mar;
    logic             en_ram;
    logic             set_ram;
    logic             set_ir;
    logic             en_acc;
    logic             set_acc;
    logic             set_tmp;
    logic             bus1;
    logic             set_flags;
    logic [2:0]       alu_op;
    logic             seq_err;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output step, ir, flags, halt_req,
        input  halted, reg_en, reg_set, en_iar, set_iar, set_mar, en_ram, set_ram,
               set_ir, en_acc, set_acc, set_tmp, bus1, set_flags, alu_op, seq_err,
               instr_cnt
    );

    modport slave (
        input  step, ir, flags, halt_req,
        output halted, reg_en, reg_set, en_iar, set_iar, set_mar, en_ram, set_ram,
               set_ir, en_acc, set_acc, set_tmp, bus1, set_flags, alu_op, seq_err,
               instr_cnt
    );
endinterface

// File: rtl/step_decoder.sv
// Decodes the one-hot stepper phase and IR into registered datapath controls (1-cycle latency),
// checks step ordering, counts instructions and stops at an instruction boundary on halt_req.
module step_decoder #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    step_decoder_if.slave sd
);
    localparam logic [5:0] S1 = 6'b000001;
    localparam logic [5:0] S2 = 6'b000010;
    localparam logic [5:0] S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000;
    localparam logic [5:0] S5 = 6'b010000;
    localparam logic [5:0] S6 = 6'b100000;

    typedef struct packed {
        logic [3:0] reg_en;
        logic [3:0] reg_set;
        logic       en_iar;
        logic       set_iar;
        logic       set_mar;
        logic       en_ram;
        logic       set_ram;
        logic       set_ir;
        logic       en_acc;
        logic       set_acc;
        logic       set_tmp;
        logic       bus1;
        logic       set_flags;
        logic [2:0] alu_op;
    } ctrl_t;

    ctrl_t            ctrl_d, ctrl_q;
    logic [5:0]       exp_q;
    logic             halted_q;
    logic             seq_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       ra_oh, rb_oh;
    logic [5:0]       step_nxt;

    assign ra_oh    = 4'b0001 << sd.ir[3:2];
    assign rb_oh    = 4'b0001 << sd.ir[1:0];
    assign step_nxt = {sd.step[4:0], sd.step[5]};

    // Pure decode of the presented step/IR; legality and halt gating happen at the register.
    always_comb begin
        ctrl_d = '0;
        case (sd.step)
            S1: begin
                ctrl_d.bus1 = 1'b1; ctrl_d.en_iar = 1'b1;
                ctrl_d.set_mar = 1'b1; ctrl_d.set_acc = 1'b1;
            end
            S2: begin
                ctrl_d.en_ram = 1'b1; ctrl_d.set_ir = 1'b1;
            end
            S3: begin
                ctrl_d.en_acc = 1'b1; ctrl_d.set_iar = 1'b1;
            end
            S4: begin
                if (sd.ir[7]) begin
                    ctrl_d.reg_en = rb_oh; ctrl_d.set_tmp = 1'b1;
                end else begin
                    case (sd.ir[6:4])
                        3'd0, 3'd1: begin
                            ctrl_d.reg_en = ra_oh; ctrl_d.set_mar = 1'b1;
                        end
                        3'd2, 3'd5: begin
                            ctrl_d.bus1 = 1'b1; ctrl_d.en_iar = 1'b1;
                            ctrl_d.set_mar = 1'b1; ctrl_d.set_acc = 1'b1;
                        end
                        3'd3: begin
                            ctrl_d.reg_en = rb_oh; ctrl_d.set_iar = 1'b1;
                        end
                        3'd4: begin
                            ctrl_d.en_iar = 1'b1; ctrl_d.set_mar = 1'b1;
                        end
                        3'd6: begin
                            ctrl_d.bus1 = 1'b1; ctrl_d.set_flags = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S5: begin
                if (sd.ir[7]) begin
                    ctrl_d.reg_en  = ra_oh;   ctrl_d.alu_op    = sd.ir[6:4];
                    ctrl_d.set_acc = 1'b1;    ctrl_d.set_flags = 1'b1;
                end else begin
                    case (sd.ir[6:4])
                        3'd0, 3'd2: begin
                            ctrl_d.en_ram = 1'b1; ctrl_d.reg_set = rb_oh;
                        end
                        3'd1: begin
                            ctrl_d.reg_en = rb_oh; ctrl_d.set_ram = 1'b1;
                        end
                        3'd4: begin
                            ctrl_d.en_ram = 1'b1; ctrl_d.set_iar = 1'b1;
                        end
                        3'd5: begin
                            ctrl_d.en_acc = 1'b1; ctrl_d.set_iar = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S6: begin
                // CMP only updates flags, so its write-back is dropped.
                if (sd.ir[7]) begin
                    if (sd.ir[6:4] != 3'b111) begin
                        ctrl_d.en_acc = 1'b1; ctrl_d.reg_set = rb_oh;
                    end
                end else if (sd.ir[6:4] == 3'd2) begin
                    ctrl_d.en_acc = 1'b1; ctrl_d.set_iar = 1'b1;
                end else if (sd.ir[6:4] == 3'd5 && |(sd.ir[3:0] & sd.flags)) begin
                    ctrl_d.en_ram = 1'b1; ctrl_d.set_iar = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            exp_q     <= S1;
            halted_q  <= 1'b0;
            seq_err_q <= 1'b0;
            cnt_q     <= '0;
        end else if (halted_q) begin
            ctrl_q <= '0;
            exp_q  <= S1;
            if (!sd.halt_req) halted_q <= 1'b0;
        end else begin
            ctrl_q <= '0;
            if (sd.step == exp_q) begin
                ctrl_q <= ctrl_d;
                exp_q  <= step_nxt;
                if (sd.step[5]) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (sd.halt_req) halted_q <= 1'b1;
                end
            end else if (sd.step != 6'b0) begin
                // Resync to the phase after a single bad step; multi-hot restarts the instruction.
                seq_err_q <= 1'b1;
                exp_q     <= $onehot(sd.step) ? step_nxt : S1;
            end
        end
    end

    assign sd.reg_en    = ctrl_q.reg_en;
    assign sd.reg_set   = ctrl_q.reg_set;
    assign sd.en_iar    = ctrl_q.en_iar;
    assign sd.set_iar   = ctrl_q.set_iar;
    assign sd.set_mar   = ctrl_q.set_mar;
    assign sd.en_ram    = ctrl_q.en_ram;
    assign sd.set_ram   = ctrl_q.set_ram;
    assign sd.set_ir    = ctrl_q.set_ir;
    assign sd.en_acc    = ctrl_q.en_acc;
    assign sd.set_acc   = ctrl_q.set_acc;
    assign sd.set_tmp   = ctrl_q.set_tmp;
    assign sd.bus1      = ctrl_q.bus1;
    assign sd.set_flags = ctrl_q.set_flags;
    assign sd.alu_op    = ctrl_q.alu_op;
    assign sd.halted    = halted_q;
    assign sd.seq_err   = seq_err_q;
    assign sd.instr_cnt = cnt_q;
endmodule

// File: tb/tb_step_decoder.sv
// Directed bench for step_decoder with a 2-bit instruction counter.
module tb_step_decoder;
    localparam int CNT_W = 2;

    localparam logic [5:0] S1 = 6'b000001;
    localparam logic [5:0] S2 = 6'b000010;
    localparam logic [5:0] S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000;
    localparam logic [5:0] S5 = 6'b010000;
    localparam logic [5:0] S6 = 6'b100000;

    localparam logic [10:0] EN_IAR    = 11'h400;
    localparam logic [10:0] SET_IAR   = 11'h200;
    localparam logic [10:0] SET_MAR   = 11'h100;
    localparam logic [10:0] EN_RAM    = 11'h080;
    localparam logic [10:0] SET_RAM   = 11'h040;
    localparam logic [10:0] SET_IR    = 11'h020;
    localparam logic [10:0] EN_ACC    = 11'h010;
    localparam logic [10:0] SET_ACC   = 11'h008;
    localparam logic [10:0] SET_TMP   = 11'h004;
    localparam logic [10:0] BUS1      = 11'h002;
    localparam logic [10:0] SET_FLAGS = 11'h001;
    localparam logic [10:0] FETCH1    = BUS1 | EN_IAR | SET_MAR | SET_ACC;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    step_decoder_if #(.CNT_W(CNT_W)) sd ();
    step_decoder #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .sd(sd));

    always #5 clk = ~clk;

    function automatic logic [21:0] exp_ctl(input logic [3:0] re, input logic [3:0] rs,
                                            input logic [10:0] f, input logic [2:0] op);
        return {re, rs, f, op};
    endfunction

    function automatic logic [21:0] obs_ctl();
        return {sd.reg_en, sd.reg_set, sd.en_iar, sd.set_iar, sd.set_mar, sd.en_ram,
                sd.set_ram, sd.set_ir, sd.en_acc, sd.set_acc, sd.set_tmp, sd.bus1,
                sd.set_flags, sd.alu_op};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stp(input logic [5:0] s, input string tag, input logic [21:0] exp);
        sd.step = s;
        tick();
        check(tag, 32'(obs_ctl()), 32'(exp));
    endtask

    task automatic fetch(input logic [7:0] i);
        sd.ir = i;
        stp(S1, "fetch_s1", exp_ctl(4'b0, 4'b0, FETCH1, 3'b0));
        stp(S2, "fetch_s2", exp_ctl(4'b0, 4'b0, EN_RAM | SET_IR, 3'b0));
        stp(S3, "fetch_s3", exp_ctl(4'b0, 4'b0, EN_ACC | SET_IAR, 3'b0));
    endtask

    initial begin
        sd.step = '0; sd.ir = '0; sd.flags = '0; sd.halt_req = 1'b0;
        tick();
        tick();
        check("rst_ctl", 32'(obs_ctl()), 32'd0);
        check("rst_seq_err", 32'(sd.seq_err), 32'd0);
        check("rst_halted", 32'(sd.halted), 32'd0);
        check("rst_cnt", 32'(sd.instr_cnt), 32'd0);
        reset = 1'b0;

        // ADD RA=1 RB=2
        fetch(8'h86);
        stp(S4, "add_s4", exp_ctl(4'b0100, 4'b0, SET_TMP, 3'b0));
        stp(S5, "add_s5", exp_ctl(4'b0010, 4'b0, SET_ACC | SET_FLAGS, 3'b000));
        stp(S6, "add_s6", exp_ctl(4'b0, 4'b0100, EN_ACC, 3'b0));
        check("add_cnt", 32'(sd.instr_cnt), 32'd1);

        // CMP: flags only, no write-back
        fetch(8'hF6);
        stp(S4, "cmp_s4", exp_ctl(4'b0100, 4'b0, SET_TMP, 3'b0));
        stp(S5, "cmp_s5", exp_ctl(4'b0010, 4'b0, SET_ACC | SET_FLAGS, 3'b111));
        stp(S6, "cmp_s6", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        check("cmp_cnt", 32'(sd.instr_cnt), 32'd2);

        // JCond on E, taken then not taken
        sd.flags = 4'b0010;
        fetch(8'h52);
        stp(S4, "jc_s4", exp_ctl(4'b0, 4'b0, FETCH1, 3'b0));
        stp(S5, "jc_s5", exp_ctl(4'b0, 4'b0, EN_ACC | SET_IAR, 3'b0));
        stp(S6, "jc_taken_s6", exp_ctl(4'b0, 4'b0, EN_RAM | SET_IAR, 3'b0));
        check("jc_cnt", 32'(sd.instr_cnt), 32'd3);
        sd.flags = 4'b0101;
        fetch(8'h52);
        stp(S4, "jcn_s4", exp_ctl(4'b0, 4'b0, FETCH1, 3'b0));
        stp(S5, "jcn_s5", exp_ctl(4'b0, 4'b0, EN_ACC | SET_IAR, 3'b0));
        stp(S6, "jc_nottaken_s6", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        check("cnt_wrap", 32'(sd.instr_cnt), 32'd0);
        sd.flags = 4'b0000;

        // Skipped step s3, then resync to s5 (LD RA=1 RB=2)
        sd.ir = 8'h06;
        stp(S1, "skip_s1", exp_ctl(4'b0, 4'b0, FETCH1, 3'b0));
        stp(S2, "skip_s2", exp_ctl(4'b0, 4'b0, EN_RAM | SET_IR, 3'b0));
        check("seq_err_clean", 32'(sd.seq_err), 32'd0);
        stp(S4, "skip_s4", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        check("seq_err_skip", 32'(sd.seq_err), 32'd1);
        stp(S5, "ld_s5_resync", exp_ctl(4'b0, 4'b0100, EN_RAM, 3'b0));
        stp(S6, "ld_s6", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        check("ld_cnt", 32'(sd.instr_cnt), 32'd1);

        // Multi-hot restarts at s1; ST RA=2 RB=3 with an idle cycle in the middle
        stp(6'b000011, "multihot", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        check("seq_err_sticky", 32'(sd.seq_err), 32'd1);
        fetch(8'h1B);
        stp(6'b0, "idle", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        stp(S4, "st_s4", exp_ctl(4'b0100, 4'b0, SET_MAR, 3'b0));
        stp(S5, "st_s5", exp_ctl(4'b1000, 4'b0, SET_RAM, 3'b0));
        stp(S6, "st_s6", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        check("st_cnt", 32'(sd.instr_cnt), 32'd2);

        // JMPR R0 with halt at s6
        fetch(8'h30);
        stp(S4, "jmpr_s4", exp_ctl(4'b0001, 4'b0, SET_IAR, 3'b0));
        stp(S5, "jmpr_s5", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        sd.halt_req = 1'b1;
        stp(S6, "jmpr_s6", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        check("halt_set", 32'(sd.halted), 32'd1);
        check("halt_cnt", 32'(sd.instr_cnt), 32'd3);
        sd.ir = 8'h23;
        stp(S1, "halted_s1", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        stp(S2, "halted_s2", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        check("halt_hold", 32'(sd.halted), 32'd1);
        sd.halt_req = 1'b0;
        stp(6'b0, "release", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        check("halt_clear", 32'(sd.halted), 32'd0);
        check("halt_no_err", 32'(sd.seq_err), 32'd1);

        // DATA into R3 after resuming
        fetch(8'h23);
        stp(S4, "data_s4", exp_ctl(4'b0, 4'b0, FETCH1, 3'b0));
        stp(S5, "data_s5", exp_ctl(4'b0, 4'b1000, EN_RAM, 3'b0));
        stp(S6, "data_s6", exp_ctl(4'b0, 4'b0, EN_ACC | SET_IAR, 3'b0));
        check("data_cnt", 32'(sd.instr_cnt), 32'd0);

        // CLF
        fetch(8'h60);
        stp(S4, "clf_s4", exp_ctl(4'b0, 4'b0, BUS1 | SET_FLAGS, 3'b0));
        stp(S5, "clf_s5", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        stp(S6, "clf_s6", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        check("clf_cnt", 32'(sd.instr_cnt), 32'd1);

        // Reset mid-instruction, then s4 is out of order
        fetch(8'h86);
        reset = 1'b1;
        stp(S4, "midrst_ctl", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        check("midrst_cnt", 32'(sd.instr_cnt), 32'd0);
        check("midrst_seq_err", 32'(sd.seq_err), 32'd0);
        reset = 1'b0;
        stp(S4, "postrst_s4", exp_ctl(4'b0, 4'b0, 11'b0, 3'b0));
        check("postrst_seq_err", 32'(sd.seq_err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
